// File: rtl/reg_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_scoreboard: register RAW-hazard scoreboard between decode and execute|
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module reg_scoreboard #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 3,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue_valid,
  output logic                              issue_ready,
  input  logic                              issue_rs1_en,
  input  logic [ADDR_WIDTH-1:0]             issue_rs1,
  input  logic                              issue_rs2_en,
  input  logic [ADDR_WIDTH-1:0]             issue_rs2,
  input  logic                              issue_regW,
  input  logic [ADDR_WIDTH-1:0]             issue_rd,
  input  logic                              wb_valid,
  input  logic [ADDR_WIDTH-1:0]             wb_rd,
  input  logic                              flush,
  output logic                              stall_raw,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err_underflow
);

  localparam int c_nreg = 1 << ADDR_WIDTH;
  localparam int c_cw   = $clog2(DEPTH + 1);
  localparam int c_tw   = $clog2(MAX_INFLIGHT + 1);

  logic [c_nreg-1:0][c_cw-1:0] w_cnt;
  logic [c_tw-1:0]             r_tot;
  logic                        r_err;

  logic            w_wb_trk, w_wb_under, w_wb_dec;
  logic            w_hit1, w_hit2, w_hitd;
  logic [c_cw-1:0] w_eff1, w_eff2, w_effd;
  logic            w_raw, w_trk_wr, w_cap, w_inc;

  // x0 is hardwired zero so it can never look busy.
  assign w_cnt[0] = '0;

  assign w_wb_trk   = wb_valid && (wb_rd != '0);
  assign w_wb_under = w_wb_trk && ((w_cnt[wb_rd] == '0) || (r_tot == '0));
  assign w_wb_dec   = w_wb_trk && !w_wb_under;

  // Same-cycle writeback bypass: a register retiring now no longer blocks.
  assign w_hit1 = wb_valid && (wb_rd == issue_rs1) && (w_cnt[issue_rs1] != '0);
  assign w_hit2 = wb_valid && (wb_rd == issue_rs2) && (w_cnt[issue_rs2] != '0);
  assign w_hitd = wb_valid && (wb_rd == issue_rd)  && (w_cnt[issue_rd]  != '0);
  assign w_eff1 = w_cnt[issue_rs1] - c_cw'(w_hit1);
  assign w_eff2 = w_cnt[issue_rs2] - c_cw'(w_hit2);
  assign w_effd = w_cnt[issue_rd]  - c_cw'(w_hitd);

  assign w_raw = (issue_rs1_en && (issue_rs1 != '0) && (w_eff1 != '0)) ||
                 (issue_rs2_en && (issue_rs2 != '0) && (w_eff2 != '0));

  assign w_trk_wr = issue_regW && (issue_rd != '0);
  assign w_cap    = w_trk_wr && ((w_effd == c_cw'(DEPTH)) ||
                                 ((r_tot - c_tw'(w_wb_dec)) == c_tw'(MAX_INFLIGHT)));

  assign issue_ready   = !rst && !flush && !w_raw && !w_cap;
  assign stall_raw     = !rst && issue_valid && w_raw && !flush;
  assign w_inc         = issue_valid && issue_ready && w_trk_wr;
  assign inflight      = r_tot;
  assign err_underflow = r_err;

  for (genvar r = 1; r < c_nreg; r++) begin : g_cnt
    logic            r_c;
    logic [c_cw-1:0] r_val;
    logic            w_up, w_dn;
    assign w_up = w_inc    && (issue_rd == ADDR_WIDTH'(r));
    assign w_dn = w_wb_dec && (wb_rd    == ADDR_WIDTH'(r));
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                r_val <= '0;
      else if (flush)         r_val <= '0;
      else if (w_up && !w_dn) r_val <= r_val + 1'b1;
      else if (w_dn && !w_up) r_val <= r_val - 1'b1;
    end
    assign r_c      = 1'b0;
    assign w_cnt[r] = r_val | {c_cw{r_c}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_tot <= '0;
    else if (flush)               r_tot <= '0;
    else if (w_inc && !w_wb_dec)  r_tot <= r_tot + 1'b1;
    else if (w_wb_dec && !w_inc)  r_tot <= r_tot - 1'b1;
  end

  // Sticky until reset; a flush does not clear it and masks same-cycle events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_err <= 1'b0;
    else if (!flush && w_wb_under) r_err <= 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_scoreboard: directed self-checking bench for reg_scoreboard       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_ready;
  logic       issue_rs1_en, issue_rs2_en, issue_regW;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush, stall_raw, err_underflow;
  logic [3:0] inflight;

  int n_chk  = 0;
  int n_fail = 0;

  reg_scoreboard #(.ADDR_WIDTH(5), .DEPTH(3), .MAX_INFLIGHT(8)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1_en(issue_rs1_en), .issue_rs1(issue_rs1),
    .issue_rs2_en(issue_rs2_en), .issue_rs2(issue_rs2),
    .issue_regW(issue_regW), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall_raw(stall_raw), .inflight(inflight), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1_en = 0; issue_rs1 = 0; issue_rs2_en = 0; issue_rs2 = 0;
    issue_regW = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    issue_valid = 1; issue_regW = 1; issue_rd = rd;
  endtask

  task automatic issue_rd1(input logic [4:0] rs);
    idle();
    issue_valid = 1; issue_rs1_en = 1; issue_rs1 = rs;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick(); tick();
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", issue_ready); end
    n_chk++; if (stall_raw !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall_raw); end
    n_chk++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL rst_inflight: got %0d want 0", inflight); end
    n_chk++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_underflow); end
    rst = 0;
    #1;
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", issue_ready); end
  endtask

  task automatic test_reset_mid();
    issue_wr(5'd5);
    #1;
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL mid_issue_ready: got %b want 1", issue_ready); end
    tick();
    issue_rd1(5'd5);
    #1;
    n_chk++; if (inflight !== 4'd1) begin n_fail++; $display("FAIL mid_inflight: got %0d want 1", inflight); end
    n_chk++; if (stall_raw !== 1'b1 || issue_ready !== 1'b0) begin n_fail++; $display("FAIL mid_raw: stall=%b ready=%b want 1/0", stall_raw, issue_ready); end
    rst = 1;
    #1;
    n_chk++; if (inflight !== 4'd0 || issue_ready !== 1'b0) begin n_fail++; $display("FAIL mid_async: inflight=%0d ready=%b want 0/0", inflight, issue_ready); end
    tick();
    rst = 0;
    #1;
    n_chk++; if (issue_ready !== 1'b1 || stall_raw !== 1'b0) begin n_fail++; $display("FAIL mid_after_rst: ready=%b stall=%b want 1/0", issue_ready, stall_raw); end
    tick();
    idle();
  endtask

  task automatic test_raw();
    issue_wr(5'd3);
    tick();
    issue_rd1(5'd3);
    #1;
    n_chk++; if (stall_raw !== 1'b1 || issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: stall=%b ready=%b want 1/0", stall_raw, issue_ready); end
    tick();
    n_chk++; if (inflight !== 4'd1) begin n_fail++; $display("FAIL raw_hold_inflight: got %0d want 1", inflight); end
    wb_valid = 1; wb_rd = 5'd3;
    #1;
    n_chk++; if (issue_ready !== 1'b1 || stall_raw !== 1'b0) begin n_fail++; $display("FAIL raw_bypass: ready=%b stall=%b want 1/0", issue_ready, stall_raw); end
    tick();
    issue_rd1(5'd3);
    #1;
    n_chk++; if (inflight !== 4'd0 || issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_cleared: inflight=%0d ready=%b want 0/1", inflight, issue_ready); end
    tick();
    idle();
  endtask

  task automatic test_x0();
    issue_wr(5'd0);
    issue_rs2_en = 1; issue_rs2 = 5'd0;
    #1;
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready1: got %b want 1", issue_ready); end
    tick();
    #1;
    n_chk++; if (issue_ready !== 1'b1 || stall_raw !== 1'b0) begin n_fail++; $display("FAIL x0_ready2: ready=%b stall=%b want 1/0", issue_ready, stall_raw); end
    tick();
    idle();
    wb_valid = 1; wb_rd = 5'd0;
    tick();
    idle();
    n_chk++; if (inflight !== 4'd0 || err_underflow !== 1'b0) begin n_fail++; $display("FAIL x0_wb: inflight=%0d err=%b want 0/0", inflight, err_underflow); end
  endtask

  task automatic test_depth();
    for (int i = 0; i < 3; i++) begin
      issue_wr(5'd7);
      tick();
    end
    #1;
    n_chk++; if (inflight !== 4'd3) begin n_fail++; $display("FAIL depth_inflight: got %0d want 3", inflight); end
    n_chk++; if (issue_ready !== 1'b0 || stall_raw !== 1'b0) begin n_fail++; $display("FAIL depth_block: ready=%b stall=%b want 0/0", issue_ready, stall_raw); end
    wb_valid = 1; wb_rd = 5'd7;
    #1;
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL depth_bypass: got %b want 1", issue_ready); end
    tick();
    wb_valid = 0;
    #1;
    n_chk++; if (inflight !== 4'd3 || issue_ready !== 1'b0) begin n_fail++; $display("FAIL depth_after: inflight=%0d ready=%b want 3/0", inflight, issue_ready); end
    idle();
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_rd = 5'd7;
      tick();
    end
    idle();
    n_chk++; if (inflight !== 4'd0 || err_underflow !== 1'b0) begin n_fail++; $display("FAIL depth_drain: inflight=%0d err=%b want 0/0", inflight, err_underflow); end
  endtask

  task automatic test_capacity();
    for (int i = 1; i <= 8; i++) begin
      issue_wr(5'(i));
      tick();
    end
    issue_wr(5'd9);
    #1;
    n_chk++; if (inflight !== 4'd8) begin n_fail++; $display("FAIL cap_inflight: got %0d want 8", inflight); end
    n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL cap_block: got %b want 0", issue_ready); end
    issue_rd1(5'd10);
    #1;
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL cap_nonwrite: got %b want 1", issue_ready); end
    tick();
    issue_wr(5'd9);
    wb_valid = 1; wb_rd = 5'd1;
    #1;
    n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL cap_bypass: got %b want 1", issue_ready); end
    tick();
    idle();
    n_chk++; if (inflight !== 4'd8) begin n_fail++; $display("FAIL cap_swap: got %0d want 8", inflight); end
  endtask

  task automatic test_flush_underflow();
    issue_wr(5'd12);
    issue_rs1_en = 1; issue_rs1 = 5'd2;
    wb_valid = 1; wb_rd = 5'd3;
    flush = 1;
    #1;
    n_chk++; if (issue_ready !== 1'b0 || stall_raw !== 1'b0) begin n_fail++; $display("FAIL flush_comb: ready=%b stall=%b want 0/0", issue_ready, stall_raw); end
    tick();
    issue_rd1(5'd12);
    #1;
    n_chk++; if (inflight !== 4'd0 || issue_ready !== 1'b1) begin n_fail++; $display("FAIL flush_clear: inflight=%0d ready=%b want 0/1", inflight, issue_ready); end
    n_chk++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL flush_noerr: got %b want 0", err_underflow); end
    tick();
    idle();
    wb_valid = 1; wb_rd = 5'd2;
    tick();
    idle();
    n_chk++; if (err_underflow !== 1'b1 || inflight !== 4'd0) begin n_fail++; $display("FAIL uf_set: err=%b inflight=%0d want 1/0", err_underflow, inflight); end
    flush = 1;
    tick();
    idle();
    tick();
    n_chk++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_reset_mid();
    test_raw();
    test_x0();
    test_depth();
    test_capacity();
    test_flush_underflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
